// File: rtl/lsu_mem_master.sv
// ============================================================================
// lsu_mem_master
// ----------------------------------------------------------------------------
// Load/store initiator between the RV32I execute stage and the unified,
// word-addressed memory. Every RV32I load/store becomes word-wide memory
// cycles:
//   lb/lh/lw/lbu/lhu : one word read, then lane extraction + extension
//   sb/sh            : read-modify-write (memory only writes whole words)
//   sw               : single word write
//
// Optional feature macro: LSU_ALIGN_CHECK_EN
//   defined   -> misaligned accesses and illegal funct3 raise rsp_err with
//                no memory cycle
//   undefined -> rsp_err tied low; illegal funct3 falls back to lw/sw,
//                misaligned word accesses use the word address and halfword
//                accesses ignore addr[0]
//
// Ports:
//   clk, rst_n       rising-edge clock, asynchronous active-low reset
//   req_valid/ready  request handshake (ready only while idle)
//   req_we           1 = store, 0 = load
//   req_funct3       RV32I funct3 of the access
//   req_addr         byte address
//   req_wdata        store data, value in the LSBs
//   rsp_valid        one-cycle completion pulse
//   rsp_rdata        extended load result (0 for stores and errors)
//   rsp_err          error flag, valid with rsp_valid
//   mem_addr         word-aligned memory address
//   mem_write        memory write enable
//   mem_wdata        memory write data
//   mem_rdata        memory read data (combinational from mem_addr)
// ============================================================================
module lsu_mem_master #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } state_t;

    state_t            state_q;
    logic [1:0]        addr_lo_q;
    logic [2:0]        funct3_q;
    logic [31:0]       wdata_q;

    logic              req_ready_q;
    logic              rsp_valid_q;
    logic [31:0]       rsp_rdata_q;
    logic              rsp_err_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              mem_write_q;
    logic [31:0]       mem_wdata_q;

    logic              f3_illegal_d;
    logic [2:0]        req_f3_d;
    logic              req_err_d;
    logic [7:0]        rd_byte_d;
    logic [15:0]       rd_half_d;
    logic [31:0]       load_data_d;
    logic [31:0]       merge_d;

    // Request decode. Illegal encodings are folded onto lw/sw so the rest of
    // the datapath only ever sees lb/lh/lw/lbu/lhu or sb/sh/sw.
    always_comb begin
        f3_illegal_d = req_we ? (req_funct3 > 3'b010)
                              : ((req_funct3 == 3'b011) || (req_funct3 >= 3'b110));
        req_f3_d     = f3_illegal_d ? 3'b010 : req_funct3;
`ifdef LSU_ALIGN_CHECK_EN
        req_err_d    = f3_illegal_d
                     || ((req_f3_d[1:0] == 2'b01) && req_addr[0])
                     || ((req_f3_d == 3'b010) && (req_addr[1:0] != 2'b00));
`else
        req_err_d    = 1'b0;
`endif
    end

    // Lane selection on the word read back from memory: extraction for loads,
    // byte/halfword merge for the read-modify-write of sb/sh.
    always_comb begin
        case (addr_lo_q)
            2'd0:    rd_byte_d = mem_rdata[7:0];
            2'd1:    rd_byte_d = mem_rdata[15:8];
            2'd2:    rd_byte_d = mem_rdata[23:16];
            default: rd_byte_d = mem_rdata[31:24];
        endcase
        rd_half_d = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (funct3_q)
            3'b000:  load_data_d = {{24{rd_byte_d[7]}}, rd_byte_d};
            3'b001:  load_data_d = {{16{rd_half_d[15]}}, rd_half_d};
            3'b100:  load_data_d = {24'd0, rd_byte_d};
            3'b101:  load_data_d = {16'd0, rd_half_d};
            default: load_data_d = mem_rdata;
        endcase

        merge_d = mem_rdata;
        if (funct3_q[0]) begin
            if (addr_lo_q[1]) merge_d[31:16] = wdata_q[15:0];
            else              merge_d[15:0]  = wdata_q[15:0];
        end else begin
            case (addr_lo_q)
                2'd0:    merge_d[7:0]   = wdata_q[7:0];
                2'd1:    merge_d[15:8]  = wdata_q[7:0];
                2'd2:    merge_d[23:16] = wdata_q[7:0];
                default: merge_d[31:24] = wdata_q[7:0];
            endcase
        end
    end

    // Access sequencer. All outputs are registered here so nothing on the
    // request side reaches the memory port combinationally, and reset drops
    // mem_write asynchronously so an interrupted store never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_lo_q   <= '0;
            funct3_q    <= '0;
            wdata_q     <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_write_q <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready_q) begin
                        addr_lo_q   <= req_addr[1:0];
                        funct3_q    <= req_f3_d;
                        wdata_q     <= req_wdata;
                        req_ready_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        if (req_err_d) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= 1'b1;
                        end else if (!req_we) begin
                            state_q    <= RD;
                            mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                        end else if (req_f3_d == 3'b010) begin
                            state_q     <= WR;
                            mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata_q <= req_wdata;
                            mem_write_q <= 1'b1;
                        end else begin
                            state_q    <= RMW_RD;
                            mem_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                        end
                    end
                end
                RD: begin
                    state_q     <= RESP;
                    rsp_rdata_q <= load_data_d;
                    rsp_valid_q <= 1'b1;
                    mem_addr_q  <= '0;
                end
                RMW_RD: begin
                    state_q     <= WR;
                    mem_wdata_q <= merge_d;
                    mem_write_q <= 1'b1;
                end
                WR: begin
                    state_q     <= RESP;
                    mem_write_q <= 1'b0;
                    mem_wdata_q <= '0;
                    mem_addr_q  <= '0;
                    rsp_valid_q <= 1'b1;
                end
                RESP: begin
                    state_q     <= IDLE;
                    rsp_valid_q <= 1'b0;
                    req_ready_q <= 1'b1;
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    mem_write_q <= 1'b0;
                    mem_wdata_q <= '0;
                    mem_addr_q  <= '0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign mem_addr  = mem_addr_q;
    assign mem_write = mem_write_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// ============================================================================
// tb_lsu_mem_master
// ----------------------------------------------------------------------------
// Drives lsu_mem_master against a 16-word memory and compares every response,
// latency and resulting memory word with a behavioural reference model that
// follows the RV32I load/store rules with plain arithmetic.
// Honours LSU_ALIGN_CHECK_EN the same way the design does.
// ============================================================================
module tb_lsu_mem_master;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_write;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] mem     [16];
    logic [31:0] ref_mem [16];
    logic        pl_en = 1'b0;
    logic [3:0]  pl_idx = '0;
    logic [31:0] pl_val = '0;

    int checks   = 0;
    int failures = 0;

    lsu_mem_master #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_addr   (mem_addr),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    // Word memory: combinational read, write on the rising edge, plus a
    // preload port used by the bench while the design is idle.
    assign mem_rdata = mem[mem_addr[5:2]];

    always @(posedge clk) begin
        if (pl_en)          mem[pl_idx] <= pl_val;
        else if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pl_en  = 1'b1;
        pl_idx = idx[3:0];
        pl_val = val;
        ref_mem[idx] = val;
        @(negedge clk);
        pl_en = 1'b0;
    endtask

    // Reference model: architectural effect of one access on ref_mem, the
    // expected response, the latency in cycles and the number of writes.
    task automatic refModel(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, output logic [31:0] rd, output logic err,
                            output int lat, output int nwr);
        int          idx;
        int          bo;
        int          ho;
        int          f;
        logic        illegal;
        logic [31:0] word;
        logic [31:0] b;
        logic [31:0] h;
        idx  = (addr / 4) % 16;
        bo   = addr % 4;
        ho   = (addr / 2) % 2;
        f    = f3;
        word = ref_mem[idx];
        illegal = we ? (f > 2) : (f == 3 || f >= 6);
`ifdef LSU_ALIGN_CHECK_EN
        err = illegal || ((f == 1 || f == 5) && (addr % 2 != 0)) || (f == 2 && bo != 0);
`else
        err = 1'b0;
        if (illegal) f = 2;
`endif
        rd  = '0;
        nwr = 0;
        if (err) begin
            lat = 1;
        end else if (!we) begin
            lat = 2;
            b = (word >> (8 * bo)) & 32'hFF;
            h = (word >> (16 * ho)) & 32'hFFFF;
            case (f)
                0:       rd = (b >= 128)   ? b + 32'hFFFF_FF00 : b;
                1:       rd = (h >= 32768) ? h + 32'hFFFF_0000 : h;
                4:       rd = b;
                5:       rd = h;
                default: rd = word;
            endcase
        end else begin
            nwr = 1;
            if (f == 2) begin
                lat = 2;
                ref_mem[idx] = wd;
            end else if (f == 0) begin
                lat = 3;
                ref_mem[idx] = (word & ~(32'hFF << (8 * bo))) | ((wd & 32'hFF) << (8 * bo));
            end else begin
                lat = 3;
                ref_mem[idx] = (word & ~(32'hFFFF << (16 * ho))) | ((wd & 32'hFFFF) << (16 * ho));
            end
        end
    endtask

    // One complete access: handshake, bounded wait for the response, then
    // comparison of response, latency, write activity and memory contents.
    task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wd, output logic [31:0] got);
        logic [31:0] exp_rd;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
        int          cyc;
        int          writes;
        logic [31:0] waddr;
        logic        seen;
        refModel(we, f3, addr, wd, exp_rd, exp_err, exp_lat, exp_wr);
        @(negedge clk);
        checkOutput("ready_before", {31'd0, req_ready}, 32'd1);
        checkOutput("rsp_low_before", {31'd0, rsp_valid}, 32'd0);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_we     = $urandom_range(0, 1);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        cyc    = 0;
        writes = 0;
        waddr  = '0;
        seen   = 1'b0;
        while (!seen && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (mem_write) begin
                writes++;
                waddr = mem_addr;
            end
            if (rsp_valid) seen = 1'b1;
        end
        checkOutput("latency", cyc, exp_lat);
        checkOutput("rsp_rdata", rsp_rdata, exp_rd);
        checkOutput("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        checkOutput("write_count", writes, exp_wr);
        if (exp_wr != 0)
            checkOutput("write_addr", waddr, {addr[31:2], 2'b00});
        checkOutput("mem_word", mem[addr[5:2]], ref_mem[addr[5:2]]);
        got = rsp_rdata;
    endtask

    initial begin
        logic [31:0] got;
        int          acc_idx[$];
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;

        for (int i = 0; i < 16; i++) preload(i, $urandom);

        @(negedge clk);
        checkOutput("rst_req_ready", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("rst_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        checkOutput("rst_mem_write", {31'd0, mem_write}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        rst_n = 1'b1;

        $display("[TB] directed sw / loads / sb-sh");
        preload(2, 32'h0);
        applyStimulus(1'b1, 3'b010, 32'h08, 32'hDEAD_BEEF, got);
        checkOutput("sw_word2", mem[2], 32'hDEAD_BEEF);

        preload(2, 32'h8070_F0AA);
        applyStimulus(1'b0, 3'b000, 32'h08, 32'h0, got);
        checkOutput("lb_0x08", got, 32'hFFFF_FFAA);
        applyStimulus(1'b0, 3'b100, 32'h0B, 32'h0, got);
        checkOutput("lbu_0x0B", got, 32'h0000_0080);
        applyStimulus(1'b0, 3'b001, 32'h0A, 32'h0, got);
        checkOutput("lh_0x0A", got, 32'hFFFF_8070);
        applyStimulus(1'b0, 3'b101, 32'h08, 32'h0, got);
        checkOutput("lhu_0x08", got, 32'h0000_F0AA);
        applyStimulus(1'b0, 3'b010, 32'h08, 32'h0, got);
        checkOutput("lw_0x08", got, 32'h8070_F0AA);

        preload(1, 32'h1122_3344);
        applyStimulus(1'b1, 3'b000, 32'h05, 32'h0000_00AB, got);
        checkOutput("sb_word1", mem[1], 32'h1122_AB44);
        applyStimulus(1'b1, 3'b001, 32'h06, 32'h0000_CDEF, got);
        checkOutput("sh_word1", mem[1], 32'hCDEF_AB44);

        $display("[TB] misaligned and illegal encodings");
        applyStimulus(1'b0, 3'b010, 32'h06, 32'h0, got);
        applyStimulus(1'b1, 3'b001, 32'h03, 32'h0000_1234, got);
        applyStimulus(1'b0, 3'b011, 32'h0C, 32'h0, got);
        applyStimulus(1'b1, 3'b101, 32'h10, 32'h5555_AAAA, got);
        applyStimulus(1'b0, 3'b101, 32'h0F, 32'h0, got);

        $display("[TB] reset during WR of sb");
        preload(3, 32'hA5A5_5A5A);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h0D;
        req_wdata  = 32'h0000_0055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("wr_mem_write", {31'd0, mem_write}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("rst_drop_write", {31'd0, mem_write}, 32'd0);
        checkOutput("rst_drop_rsp", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_mem_unchanged", mem[3], 32'hA5A5_5A5A);
        checkOutput("rst_ready_after", {31'd0, req_ready}, 32'd1);
        checkOutput("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);

        $display("[TB] back-to-back loads");
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        req_valid  = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (req_ready) acc_idx.push_back(i);
            @(negedge clk);
        end
        req_valid = 1'b0;
        checkOutput("b2b_accepts", acc_idx.size(), 32'd4);
        for (int i = 1; i < acc_idx.size(); i++)
            checkOutput("b2b_spacing", acc_idx[i] - acc_idx[i-1], 32'd3);
        checkOutput("b2b_last_rdata", rsp_rdata, ref_mem[4]);

        $display("[TB] randomized accesses");
        for (int n = 0; n < 60; n++) begin
            applyStimulus(1'($urandom), 3'($urandom), 32'($urandom_range(0, 63)), $urandom, got);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
